// File: rtl/wifi_tx_pkg.sv
// wifi_tx_pkg: shared rate codes, generator polynomials and puncture masks for the WIFI TX encoder
package wifi_tx_pkg;
  typedef enum logic [1:0] {RATE_1_2 = 2'd0, RATE_2_3 = 2'd1, RATE_3_4 = 2'd2} rate_t;
  localparam logic [6:0] G0 = 7'o133;
  localparam logic [6:0] G1 = 7'o171;
  localparam int HEADER_LEN = 24;
  localparam int RATE_BITS = 4;
  localparam logic [3:0] R_6 = 4'b1101;
  localparam logic [3:0] R_9 = 4'b1111;
  localparam logic [3:0] R_12 = 4'b0101;
  localparam logic [3:0] R_18 = 4'b0111;
  localparam logic [3:0] R_24 = 4'b1001;
  localparam logic [3:0] R_36 = 4'b1011;
  localparam logic [3:0] R_48 = 4'b0001;
  localparam logic [3:0] R_54 = 4'b0011;
  localparam logic [1:0] KEEP_AB = 2'b11;
  localparam logic [1:0] KEEP_A = 2'b01;
  localparam logic [1:0] KEEP_B = 2'b10;
  function automatic logic conv_bit(input logic [6:0] g, input logic d, input logic [5:0] s);
    return ^(g & {d, s[0], s[1], s[2], s[3], s[4], s[5]});
  endfunction
  function automatic logic rate_ok(input logic [3:0] r);
    return r == R_6 || r == R_9 || r == R_12 || r == R_18 || r == R_24 || r == R_36 || r == R_48 || r == R_54;
  endfunction
  function automatic rate_t decode_rate(input logic [3:0] r);
    return r == R_48 ? RATE_2_3 :
           (r == R_9 || r == R_18 || r == R_36 || r == R_54) ? RATE_3_4 : RATE_1_2;
  endfunction
endpackage

// File: rtl/wifi_tx_punct_ctrl.sv
// wifi_tx_punct_ctrl: header bit counter, on-the-fly RATE decode and puncture keep-mask generation
module wifi_tx_punct_ctrl #(
  parameter int HEADER_LEN = wifi_tx_pkg::HEADER_LEN,
  parameter int RATE_BITS = wifi_tx_pkg::RATE_BITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  input  logic       valid_in,
  output logic [1:0] keep,
  output logic [1:0] rate_out,
  output logic       rate_err
);
  import wifi_tx_pkg::*;
  localparam int CW = $clog2(HEADER_LEN + 1);
  logic [CW-1:0] bit_cnt;
  logic [1:0] punct_phase;
  logic [RATE_BITS-2:0] rate_sr;
  logic [RATE_BITS-1:0] code;
  rate_t rate_q;
  logic hdr, rate_bit, last_phase;
  always_comb begin
    hdr = bit_cnt < CW'(HEADER_LEN);
    rate_bit = bit_cnt == CW'(RATE_BITS - 1);
    code = {rate_sr, data_in};
    last_phase = rate_q == RATE_2_3 ? punct_phase == 2'd1 :
                 rate_q == RATE_3_4 ? punct_phase == 2'd2 : 1'b1;
    keep = hdr || punct_phase == 2'd0 ? KEEP_AB : punct_phase == 2'd1 ? KEEP_A : KEEP_B;
  end
  always_ff @(posedge clk)
    if (reset) begin
      bit_cnt <= '0;
      punct_phase <= 2'd0;
      rate_sr <= '0;
      rate_q <= RATE_1_2;
      rate_err <= 1'b0;
    end else if (!valid_in) begin
      bit_cnt <= '0;
      punct_phase <= 2'd0;
      rate_sr <= '0;
      rate_err <= 1'b0;
    end else begin
      if (hdr) bit_cnt <= bit_cnt + CW'(1);
      punct_phase <= hdr || last_phase ? 2'd0 : punct_phase + 2'd1;
      rate_sr <= {rate_sr[RATE_BITS-3:0], data_in};
      if (rate_bit) begin
        rate_q <= decode_rate(code);
        rate_err <= !rate_ok(code);
      end
    end
  assign rate_out = rate_q;
endmodule

// File: rtl/wifi_tx_conv_encoder.sv
// wifi_tx_conv_encoder: K=7 rate-1/2 convolutional encoder with registered coded word and puncture keep mask
module wifi_tx_conv_encoder #(
  parameter int HEADER_LEN = wifi_tx_pkg::HEADER_LEN,
  parameter int RATE_BITS = wifi_tx_pkg::RATE_BITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  input  logic       valid_in,
  output logic [1:0] data_out,
  output logic [1:0] keep_out,
  output logic       valid_out,
  output logic [1:0] rate_out,
  output logic       rate_err
);
  import wifi_tx_pkg::*;
  logic [5:0] s;
  logic [1:0] keep;
  wifi_tx_punct_ctrl #(.HEADER_LEN(HEADER_LEN), .RATE_BITS(RATE_BITS)) u_punct (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .valid_in(valid_in),
    .keep(keep),
    .rate_out(rate_out),
    .rate_err(rate_err)
  );
  always_ff @(posedge clk)
    if (reset) begin
      s <= 6'd0;
      data_out <= 2'b00;
      keep_out <= 2'b00;
      valid_out <= 1'b0;
    end else if (valid_in) begin
      s <= {s[4:0], data_in};
      data_out <= {conv_bit(G1, data_in, s), conv_bit(G0, data_in, s)};
      keep_out <= keep;
      valid_out <= 1'b1;
    end else begin
      s <= 6'd0;
      keep_out <= 2'b00;
      valid_out <= 1'b0;
    end
endmodule

// File: tb/tb_wifi_tx_conv_encoder.sv
// tb_wifi_tx_conv_encoder: vector-table and scoreboard bench for the convolutional encoder and puncturer
module tb_wifi_tx_conv_encoder;
  logic clk = 1'b0, reset = 1'b1, data_in = 1'b0, valid_in = 1'b0;
  logic [1:0] data_out, keep_out, rate_out;
  logic valid_out, rate_err;
  wifi_tx_conv_encoder dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .valid_in(valid_in),
    .data_out(data_out),
    .keep_out(keep_out),
    .valid_out(valid_out),
    .rate_out(rate_out),
    .rate_err(rate_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] data;
    logic [1:0] keep;
    logic chk_rate;
    logic [1:0] rate;
    logic err;
    logic is_data;
  } exp_t;
  typedef struct {
    logic [3:0] rc;
    int nd;
    logic [1:0] rate;
    logic err;
  } vec_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, kept = 0;
  logic [5:0] m_s = 6'd0;
  int m_cnt = 0, m_phase = 0;
  logic [1:0] m_rate = 2'd0;
  logic m_err = 1'b0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, got, want);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (valid_out === 1'b1) begin
      if (q.size() == 0) chk("unexpected_valid", 32'(valid_out), 32'd0);
      else begin
        e = q.pop_front();
        chk("data", 32'(data_out), 32'(e.data));
        chk("keep", 32'(keep_out), 32'(e.keep));
        if (e.chk_rate) begin
          chk("rate_out", 32'(rate_out), 32'(e.rate));
          chk("rate_err", 32'(rate_err), 32'(e.err));
        end
        if (e.is_data) kept += $countones(keep_out);
      end
    end
  end
  task automatic model_clear();
    m_s = 6'd0;
    m_cnt = 0;
    m_phase = 0;
  endtask
  task automatic drive_bit(input logic d);
    exp_t e;
    e.data = {d ^ m_s[0] ^ m_s[1] ^ m_s[2] ^ m_s[5], d ^ m_s[1] ^ m_s[2] ^ m_s[4] ^ m_s[5]};
    e.is_data = m_cnt >= 24;
    e.keep = !e.is_data || m_rate == 2'd0 || m_phase == 0 ? 2'b11 : m_phase == 1 ? 2'b01 : 2'b10;
    if (e.is_data) m_phase = (m_phase + 1) % (int'(m_rate) + 1);
    e.chk_rate = m_cnt >= 3;
    e.rate = m_rate;
    e.err = m_err;
    q.push_back(e);
    m_s = {m_s[4:0], d};
    m_cnt++;
    data_in = d;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    data_in = 1'b0;
    valid_in = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [3:0] rc, input int nd, input logic [1:0] rate, input logic err,
                            input logic [31:0] dbits, input logic first);
    m_rate = rate;
    m_err = err;
    for (int i = 0; i < 24; i++) begin
      drive_bit(i < 4 ? rc[3-i] : i < 18 ? 1'($urandom) : 1'b0);
      if (first && i == 0) begin
        chk("fresh_first_data", 32'(data_out), 32'd3);
        chk("fresh_first_keep", 32'(keep_out), 32'd3);
      end
    end
    for (int i = 0; i < nd; i++) drive_bit(dbits[i]);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    vec_t vt[10];
    logic [6:0] imp_a, imp_b;
    logic [1:0] last_d, last_r;
    vt[0] = '{4'b1101, 8, 2'd0, 1'b0};
    vt[1] = '{4'b0101, 7, 2'd0, 1'b0};
    vt[2] = '{4'b1001, 6, 2'd0, 1'b0};
    vt[3] = '{4'b0001, 6, 2'd1, 1'b0};
    vt[4] = '{4'b1111, 9, 2'd2, 1'b0};
    vt[5] = '{4'b0111, 10, 2'd2, 1'b0};
    vt[6] = '{4'b1011, 5, 2'd2, 1'b0};
    vt[7] = '{4'b0011, 12, 2'd2, 1'b0};
    vt[8] = '{4'b0000, 8, 2'd0, 1'b1};
    vt[9] = '{4'b1010, 4, 2'd0, 1'b1};
    imp_a = 7'b1011011;
    imp_b = 7'b1111001;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", 32'(data_out), 32'd0);
    chk("reset_keep", 32'(keep_out), 32'd0);
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_rate", 32'(rate_out), 32'd0);
    chk("reset_err", 32'(rate_err), 32'd0);
    reset = 1'b0;
    m_rate = 2'd0;
    m_err = 1'b1;
    for (int i = 0; i < 24; i++) drive_bit(1'b0);
    for (int j = 0; j < 10; j++) begin
      drive_bit(j == 0);
      chk("impulse_a", 32'(data_out[0]), j < 7 ? 32'(imp_a[6-j]) : 32'd0);
      chk("impulse_b", 32'(data_out[1]), j < 7 ? 32'(imp_b[6-j]) : 32'd0);
      chk("impulse_keep", 32'(keep_out), 32'd3);
    end
    idle();
    for (int k = 0; k < 10; k++) begin
      kept = 0;
      send_frame(vt[k].rc, vt[k].nd, vt[k].rate, vt[k].err, $urandom, 1'b0);
      last_d = data_out;
      last_r = rate_out;
      idle();
      chk("gap_valid", 32'(valid_out), 32'd0);
      chk("gap_keep", 32'(keep_out), 32'd0);
      chk("gap_data_hold", 32'(data_out), 32'(last_d));
      chk("gap_rate_hold", 32'(rate_out), 32'(last_r));
      chk("gap_err_clear", 32'(rate_err), 32'd0);
      if (vt[k].rate == 2'd1) chk("kept_bits_2_3", 32'(kept), 32'd9);
    end
    send_frame(4'b1111, 5, 2'd2, 1'b0, 32'h16, 1'b1);
    reset = 1'b1;
    data_in = 1'b1;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_valid", 32'(valid_out), 32'd0);
    chk("midreset_keep", 32'(keep_out), 32'd0);
    chk("midreset_data", 32'(data_out), 32'd0);
    reset = 1'b0;
    model_clear();
    send_frame(4'b1111, 7, 2'd2, 1'b0, $urandom, 1'b1);
    idle();
    send_frame(4'b1111, 9, 2'd2, 1'b0, 32'h1A5, 1'b0);
    idle();
    kept = 0;
    send_frame(4'b1101, 8, 2'd0, 1'b0, 32'h0F, 1'b1);
    chk("b2b_kept_all", 32'(kept), 32'd14);
    idle();
    chk("b2b_final_rate", 32'(rate_out), 32'd0);
    repeat (2) idle();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wifi_tx_conv_encoder.md
Name: wifi_tx_conv_encoder

Overview:
- Convolutional encoder and puncturer for the WIFI TX PHY, directly downstream of the scrambler.
- Consumes the scrambler's serial bit stream, 1 bit/cycle:
  - 24-bit SIGNAL header, unscrambled;
  - scrambled DATA;
  - 6 zero tail bits;
  - pad.
- Produces a registered 2-bit coded word per input bit, plus a keep mask, for the interleaver.
- Encoder: K=7, g0=133o, g1=171o. The header is always coded at rate 1/2. DATA is punctured to 1/2, 2/3 or 3/4 according to the RATE bits decoded on the fly from the header.

Parameters:
- HEADER_LEN, 24, number of leading bits coded at rate 1/2 (SIGNAL field).
- RATE_BITS, 4, number of leading header bits forming the RATE field.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- data_in  in  1  serial bit from the scrambler.
- valid_in  in  1  data_in is valid. Held high for the whole frame; a low cycle ends the frame.
- data_out  out  2  [0]=A (g0) coded bit, [1]=B (g1) coded bit.
- keep_out  out  2  per-bit keep mask. Bit [i]=1 means data_out[i] is transmitted.
- valid_out  out  1  data_out/keep_out are valid.
- rate_out  out  2  latched coding rate: 0 = 1/2, 1 = 2/3, 2 = 3/4.
- rate_err  out  1  sticky per frame; an unsupported RATE code was received.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: data_out=0, keep_out=0, valid_out=0, rate_out=0, rate_err=0. Shift register s[5:0]=0, bit_cnt=0, punct_phase=0.
- Latency: 1 cycle. The output for the input at cycle t appears at t+1.
- Encoder: s[k] holds input delayed k+1.
  - A = d^s[1]^s[2]^s[4]^s[5]
  - B = d^s[0]^s[1]^s[2]^s[5]
  - s <= {s[4:0], d} on every valid_in=1 cycle.
- bit_cnt: counts accepted bits and saturates at HEADER_LEN (5-bit width suffices).
- RATE capture:
  - Header bits 0..3 are R1..R4, in arrival order.
  - They are shifted into rate_sr. At bit index 3, decode {R1,R2,R3,R4}:
    - 1101, 0101, 1001 -> 1/2
    - 0001 -> 2/3
    - 1111, 0111, 1011, 0011 -> 3/4
    - anything else -> 1/2 with rate_err=1
  - rate_out updates the cycle after bit 3 is accepted.
- Header phase (bit_cnt < HEADER_LEN): keep_out=2'b11 for every bit.
- Data phase (bit_cnt == HEADER_LEN): punct_phase cycles through the pattern and restarts at 0 on the first data bit.
  - 1/2: keep=11 always.
  - 2/3: phase0 keep=11, phase1 keep=01 (A only). Period 2.
  - 3/4: phase0 keep=11, phase1 keep=01, phase2 keep=10 (B only). Period 3.
- Encoder state is not cleared between header and data. The header tail bits (18-23) are zero, so s is 0 naturally.
- Pad bits are encoded and punctured like data; the downstream block discards them.
- valid_in=0:
  - next cycle valid_out=0 and keep_out=0; data_out holds its last value;
  - clear s, bit_cnt, punct_phase, rate_sr and rate_err;
  - rate_out holds until the next frame's bit 3.
- Mid-frame reset: all state returns to reset values on the next edge. No partial word is emitted.
- valid_in must be continuous within a frame. A one-cycle gap ends the frame, and the next high starts a new header.
- Reset has priority over valid_in.

Decomposition:
- Shared package wifi_tx_pkg:
  - rate enum (RATE_1_2, RATE_2_3, RATE_3_4);
  - G0=7'o133, G1=7'o171;
  - HEADER_LEN;
  - the 8 RATE code constants;
  - puncture keep-pattern constants.
- One sub-module, wifi_tx_punct_ctrl: bit counter, RATE decode, punct_phase and keep-mask generation.
- The top module holds the encoder shift register and the output registers.

Test Plan:
- Impulse: header 24 zeros, then data bit 1 followed by zeros at rate 1/2.
  - Expect 7 A bits 1,0,1,1,0,1,1 and B bits 1,1,1,1,0,0,1.
  - All later outputs are 0, with keep=11.
- RATE decode: header starting R1..R4=1,1,1,1, then 9 data bits.
  - Expect rate_out=2 from the cycle after bit 3.
  - Data keep sequence 11,01,10 repeated 3 times.
  - Header keep is always 11.
- 2/3 rate: R=0,0,0,1 plus 6 data bits.
  - Expect rate_out=1 and data keep 11,01,11,01,11,01.
  - Exactly 9 transmitted coded bits.
- Invalid RATE 0000: expect rate_err=1, rate_out=0, keep=11 throughout data.
  - Drop valid_in for 1 cycle: rate_err clears; valid_out=0 on the cycle after.
- Mid-frame reset: assert reset at data bit 5 of a 3/4 frame, then start a new frame.
  - valid_out=0 during reset.
  - The new frame's first output equals a fresh-state encode: input 1 gives A=1, B=1.
  - punct_phase restarts at keep=11.
- Back-to-back frames separated by a single valid_in=0 cycle, frame 1 at 3/4 and frame 2 at 1/2.
  - Frame 2's data keep is all 11.
  - The encoder output shows no carry-over from frame 1's state.
